// File: rtl/sort_pkg.sv
// Shared types, width helper and latency function for the best-N sector sorter.
// The rank/index/winner typedefs describe the default build (BWR=6, NKEY=160).
package sort_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   localparam int SORT_BWR  = 6;
   localparam int SORT_NKEY = 160;
   localparam int SORT_KW   = clog2(SORT_NKEY);

   typedef logic [SORT_BWR-1:0] rank_t;
   typedef logic [SORT_KW-1:0]  kidx_t;

   typedef struct packed {
      rank_t q;
      kidx_t num;
   } win_t;

   // Input register + one register per LVL_PER_REG tree levels + output register (+ ghost stage).
   function automatic int sort_lat(input int nkey, input int lvl, input int gc);
      return 2 + gc + (clog2(nkey) + lvl - 1) / lvl;
   endfunction

endpackage

// File: rtl/sort_sector_bestn_zone_bestn.sv
// zone_bestn: one zone's merge tree selecting the NWIN highest ranks among NKEY keys.
// Ties resolve to the lower key index because left subtrees always hold lower indices.
module zone_bestn
   import sort_pkg::*;
#(
   parameter int  NKEY        = 160,
   parameter int  BWR         = 6,
   parameter int  NWIN        = 3,
   parameter int  LVL_PER_REG = 2,
   localparam int KW          = clog2(NKEY)
) (
   input  logic           clk,
   input  logic [BWR-1:0] rank_i [NKEY],
   output logic [BWR-1:0] q_o    [NWIN],
   output logic [KW-1:0]  num_o  [NWIN]
);

   localparam int D  = clog2(NKEY);
   localparam int NL = 1 << D;

   typedef struct packed {
      logic [BWR-1:0] q;
      logic [KW-1:0]  num;
   } node_t;

   // Element 0 (least significant) is the best entry of the list.
   typedef node_t [NWIN-1:0] list_t;

   function automatic list_t merge(input list_t a, input list_t b);
      list_t ra;
      list_t rb;
      list_t r;
      ra = a;
      rb = b;
      r  = '0;
      for (int w = 0; w < NWIN; w++) begin
         if (rb[0].q > ra[0].q) begin
            r[w] = rb[0];
            rb   = rb >> $bits(node_t);
         end else begin
            r[w] = ra[0];
            ra   = ra >> $bits(node_t);
         end
      end
      return r;
   endfunction

   for (genvar gi = 0; gi <= D; gi++) begin : g_lvl
      localparam int NN = NL >> gi;
      list_t node_o [NN];

      if (gi == 0) begin : g_leaf
         for (genvar gk = 0; gk < NL; gk++) begin : g_k
            if (gk < NKEY) begin : g_real
               assign node_o[gk] = list_t'({rank_i[gk], KW'(gk)});
            end else begin : g_pad
               assign node_o[gk] = '0;
            end
         end
      end else begin : g_node
         list_t mrg [NN];
         for (genvar gn = 0; gn < NN; gn++) begin : g_n
            assign mrg[gn] = merge(g_lvl[gi-1].node_o[2*gn], g_lvl[gi-1].node_o[2*gn+1]);
         end
         if ((gi % LVL_PER_REG) == 0 || gi == D) begin : g_reg
            always_ff @(posedge clk) begin
               node_o <= mrg;
            end
         end else begin : g_comb
            assign node_o = mrg;
         end
      end
   end

   for (genvar gw = 0; gw < NWIN; gw++) begin : g_out
      assign q_o[gw]   = g_lvl[D].node_o[0][gw].q;
      assign num_o[gw] = g_lvl[D].node_o[0][gw].num;
   end

endmodule

// File: rtl/sort_sector_bestn.sv
// sort_sector_bestn: pipelined best-NWIN sorter for NZONE independent zones of NKEY key strips.
// Defining SORT_SECTOR_BESTN_GHOST_CANCEL_EN inserts a neighbour-cancellation stage (L grows by one).
module sort_sector_bestn
   import sort_pkg::*;
#(
   parameter int  NZONE       = 4,
   parameter int  NKEY        = 160,
   parameter int  BWR         = 6,
   parameter int  NWIN        = 3,
   parameter int  LVL_PER_REG = 2,
   localparam int KW          = clog2(NKEY)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_vld,
   input  logic [BWR-1:0] ph_rank [NZONE][NKEY],
   output logic           out_vld,
   output logic [BWR-1:0] ph_q    [NZONE][NWIN],
   output logic [KW-1:0]  ph_num  [NZONE][NWIN],
   output logic           win_vld [NZONE][NWIN]
);

`ifdef SORT_SECTOR_BESTN_GHOST_CANCEL_EN
   localparam int GC = 1;
`else
   localparam int GC = 0;
`endif
   localparam int LAT = sort_lat(NKEY, LVL_PER_REG, GC);

   logic [LAT-1:0] vld_q;
   logic [BWR-1:0] rank_q  [NZONE][NKEY];
   logic [BWR-1:0] tree_in [NZONE][NKEY];
   logic [BWR-1:0] tr_q    [NZONE][NWIN];
   logic [KW-1:0]  tr_num  [NZONE][NWIN];

   // Valid travels alongside the data; only the valid bits need clearing to drop in-flight BXs.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= {vld_q[LAT-2:0], in_vld};
      end
   end

   always_ff @(posedge clk) begin
      rank_q <= ph_rank;
   end

`ifdef SORT_SECTOR_BESTN_GHOST_CANCEL_EN
   logic [BWR-1:0] gc_d [NZONE][NKEY];
   logic [BWR-1:0] gc_q [NZONE][NKEY];

   for (genvar gz = 0; gz < NZONE; gz++) begin : g_gz
      for (genvar gk = 0; gk < NKEY; gk++) begin : g_gk
         logic [BWR-1:0] lft;
         logic [BWR-1:0] rgt;
         if (gk == 0) begin : g_lo
            assign lft = '0;
         end else begin : g_li
            assign lft = rank_q[gz][gk-1];
         end
         if (gk == NKEY - 1) begin : g_ro
            assign rgt = '0;
         end else begin : g_ri
            assign rgt = rank_q[gz][gk+1];
         end
         // Strict on the left, non-strict on the right: a plateau keeps its leftmost key.
         assign gc_d[gz][gk] = (rank_q[gz][gk] > lft && rank_q[gz][gk] >= rgt) ? rank_q[gz][gk] : '0;
      end
   end

   always_ff @(posedge clk) begin
      gc_q <= gc_d;
   end

   assign tree_in = gc_q;
`else
   assign tree_in = rank_q;
`endif

   for (genvar gi = 0; gi < NZONE; gi++) begin : g_zone
      zone_bestn #(
         .NKEY        (NKEY),
         .BWR         (BWR),
         .NWIN        (NWIN),
         .LVL_PER_REG (LVL_PER_REG)
      ) u_zone (
         .clk    (clk),
         .rank_i (tree_in[gi]),
         .q_o    (tr_q[gi]),
         .num_o  (tr_num[gi])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int z = 0; z < NZONE; z++) begin
            for (int w = 0; w < NWIN; w++) begin
               ph_q[z][w]    <= '0;
               ph_num[z][w]  <= '0;
               win_vld[z][w] <= 1'b0;
            end
         end
      end else begin
         for (int z = 0; z < NZONE; z++) begin
            for (int w = 0; w < NWIN; w++) begin
               ph_q[z][w]    <= tr_q[z][w];
               ph_num[z][w]  <= (tr_q[z][w] != '0) ? tr_num[z][w] : '0;
               win_vld[z][w] <= (tr_q[z][w] != '0);
            end
         end
      end
   end

   assign out_vld = vld_q[LAT-1];

endmodule

// File: doc/sort_sector_bestn.md
Name: sort_sector_bestn

Overview:
- Parametrised, pipelined best-N pattern sorter for a full sector.
- For each of NZONE zones it selects the NWIN highest ranks among NKEY key-phi strips, and outputs their rank, index and a per-winner valid flag.
- Sits between the pattern-rank stage and the track-building/segment-matching stage.
- Successor to the fixed 4-zone/best-3 sorter:
  - adds configurable zone, key and winner counts;
  - adds an input/output valid pipeline, synchronous reset and explicit empty-winner flags.

Parameters:
- NZONE, 4, number of zones sorted in parallel.
- NKEY, 160, key-phi strips per zone; must be at least 2.
- BWR, 6, rank width in bits; rank 0 means empty.
- NWIN, 3, winners per zone; must satisfy 1 <= NWIN <= NKEY.
- LVL_PER_REG, 2, merge-tree levels per pipeline register; must be at least 1.

Ports:
- clk  in  1  sector clock.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  marks ph_rank as a valid BX.
- ph_rank  in  [BWR-1:0] x [NZONE][NKEY]  pattern ranks.
- out_vld  out  1  marks the outputs as a valid BX.
- ph_q  out  [BWR-1:0] x [NZONE][NWIN]  winner ranks; index 0 is the best.
- ph_num  out  [KW-1:0] x [NZONE][NWIN]  winner key index, where KW = clog2(NKEY).
- win_vld  out  [NZONE][NWIN]  winner is non-empty (rank != 0).

Behaviour:
- Clock and reset:
  - One clock; all state updates on the rising edge of clk.
  - While rst is high, every pipeline valid bit and every output register clears: out_vld=0, ph_q=0, ph_num=0, win_vld=0.
- Latency:
  - D = clog2(NKEY) tree levels.
  - L = 2 + ceil(D/LVL_PER_REG) cycles from in_vld/ph_rank to out_vld/outputs.
  - Defaults (D=8, LVL_PER_REG=2): L = 6.
  - Fully pipelined: accepts a new BX every cycle, no stalls, no backpressure.
- Stage 0: input register.
  - ph_rank and in_vld are registered.
  - ph_rank is captured regardless of in_vld.
- Tree:
  - Each leaf is a one-entry list {rank, index}.
  - Each node merges two sorted lists into the top-NWIN sorted list.
  - A register follows every LVL_PER_REG levels, and the final level is always registered.
  - Non-power-of-two NKEY: missing leaves are rank 0 and never reported as valid.
- Ordering:
  - Descending rank.
  - Equal ranks are ordered by lower key index first.
  - Output is deterministic and independent of LVL_PER_REG.
- Output stage (registered):
  - win_vld[z][w] = (ph_q[z][w] != 0).
  - When win_vld=0: ph_q=0 and ph_num=0.
  - When out_vld=0, outputs hold whatever the pipeline carries, except after reset when they are 0; consumers gate on out_vld.
- Boundary conditions:
  - Fewer than NWIN non-zero keys: leading winners are valid, trailing ones have win_vld=0.
  - All keys zero: all win_vld=0 while out_vld=1.
  - Duplicate index in a zone's output is never allowed.
- Reset mid-operation: all in-flight BXs are dropped. The first out_vld after rst falls comes L cycles after the first in_vld sampled with rst low.
- Zones are fully independent; no cross-zone comparison.

Optional Feature:
- Macro: SORT_SECTOR_BESTN_GHOST_CANCEL_EN.
- When defined:
  - One extra register stage after stage 0 applies neighbour cancellation, so L becomes 3 + ceil(D/LVL_PER_REG).
  - Key k survives only if rank[k] > rank[k-1] and rank[k] >= rank[k+1]; out-of-range neighbours count as 0.
  - Surviving keys keep their rank; all other keys are forced to 0.
  - Result: plateaus keep only their leftmost key.
- When undefined: no cancellation stage, and L is as stated in Behaviour.

Decomposition:
- Shared package sort_pkg holds:
  - rank/index typedefs: rank_t = logic[BWR-1:0], kidx_t = logic[KW-1:0];
  - the winner struct win_t = {rank_t q; kidx_t num;};
  - a clog2 helper function;
  - a latency constant function sort_lat(nkey, lvl, gc) so consumers can align.
- One sub-module, zone_bestn:
  - one zone's full tree with its pipeline registers;
  - instantiated NZONE times by generate.
- The two-list merge is a function inside zone_bestn, not a separate module.

Test Plan (all runs NKEY=160, NWIN=3, default parameters unless noted):
- Single hit: zone 0 key 37 rank 5, all else 0, in_vld=1 -> 6 cycles later out_vld=1; ph_q[0]={5,0,0}, ph_num[0]={37,0,0}, win_vld[0]={1,0,0}; zones 1-3 all win_vld=0.
- Ties: zone 2 keys 10, 90, 150 rank 7 and key 5 rank 3 -> ph_num[2]={10,90,150}, ph_q[2]={7,7,7}; key 5 is dropped.
- Streaming: 10 consecutive BXs with one distinct max per BX (rank 63 at key = BX number) -> 10 consecutive out_vld cycles in order, each ph_num[z][0] matching its BX.
- Reset mid-flight: 3 BXs injected, rst pulsed for 1 cycle at cycle 2 -> none of them ever appears on out_vld; a BX injected after reset emerges exactly L cycles later.
- Non-power-of-two and depth: NKEY=100, LVL_PER_REG=1, top ranks at keys 99, 0, 50 -> L=9; ph_num order follows rank; no index >= 100 is ever reported.
- Ghost cancel (macro on): zone 1 keys 20-22 all rank 4, key 23 rank 6 -> survivors are key 20 (rank 4) and key 23 (rank 6); ph_num[1]={23,20,0}, win_vld={1,1,0}, L=7.
